fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 16-bit pipelined core. It owns the PC and issues requests to instruction memory over a req/ready handshake that supports variable latency. It loads the IF/ID pipeline register with the fetched instruction and PC+2. It handles decode-stage stalls through a one-entry skid buffer, branch redirects from later stages, and stops fetching after a HLT (opcode 4'hF).

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- HLT_OPCODE, 4'hF, opcode (instr[15:12]) that stops fetch
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hazard unit: hold IF/ID contents
- redirect_en  in  1  taken branch / flush from later stage
- redirect_pc  in  16  new PC; bit 0 forced to 0
- imem_req  out  1  instruction memory request
- imem_addr  out  16  fetch address; equals pc
- imem_rdata  in  16  fetched instruction; valid when imem_ready=1
- imem_ready  in  1  request complete this cycle (may be same cycle as req)
- ifid_valid  out  1  IF/ID holds a live instruction
- ifid_instr  out  16  IF/ID instruction
- ifid_pc_inc  out  16  IF/ID PC+2 of that instruction, used by PCS and branches
- pc  out  16  current fetch PC
- halted  out  1  fetch stopped on HLT

## Operation
- State encoding: FETCH, BUFFERED, DISCARD, HALT. Registers: pc, state, IF/ID (valid, instr, pc_inc), skid buffer (buf_valid, buf_instr, buf_pc_inc, buf_hlt).
- imem_req=1 in FETCH and DISCARD, otherwise 0. imem_addr=pc always. Both are held stable while req=1 and ready=0.
- Accept: in FETCH, an accept happens in any cycle with imem_ready=1 and redirect_en=0.
  - Non-HLT, stall=0: IF/ID <= {1, rdata, pc+2}; pc <= pc+2; stay FETCH.
  - Non-HLT, stall=1: IF/ID held; buffer <= {1, rdata, pc+2, 0}; pc <= pc+2; go to BUFFERED.
  - HLT, stall=0: IF/ID loaded as above; pc unchanged; go to HALT.
  - HLT, stall=1: buffer loaded with buf_hlt=1; pc unchanged; go to BUFFERED.
- FETCH, imem_ready=0, stall=0: IF/ID <= valid=0 (bubble).
- FETCH, imem_ready=0, stall=1: IF/ID held.
- BUFFERED: no request is issued. When stall=0: IF/ID <= buffer; buf_valid <= 0; go to HALT if buf_hlt, else FETCH.
- HALT: no request; IF/ID <= valid=0 when stall=0. halted=1 only in this state.
- Redirect has priority over stall and over accept, in all states:
  - pc <= {redirect_pc[15:1], 0}; ifid_valid <= 0; buf_valid <= 0.
  - Next state is DISCARD if a request is outstanding (state FETCH, imem_req=1, imem_ready=0); otherwise FETCH. This includes leaving HALT, since a HLT fetched behind a taken branch is speculative.
- DISCARD: req/addr stay at the old address, which is latched in a separate discard address register, until imem_ready. The returned data is dropped. Then go to FETCH at the redirected pc.
  - A redirect during DISCARD updates the target pc only.
- Arithmetic: pc+2 is modulo 2^16, so 16'hFFFE wraps to 16'h0000. Bit 0 of pc is always 0.

## Timing
- Reset values while rst=1 and after it releases:
  - pc=RESET_PC, state=FETCH, imem_req=1.
  - ifid_valid=0, ifid_instr=16'h0000, ifid_pc_inc=16'h0000.
  - buf_valid=0, halted=0.
- Reset asserted mid-request abandons the request; the memory is reset by the same rst.
- Latency: an instruction whose imem_ready is high in cycle N is visible on ifid_* in cycle N+1.
- Throughput: one instruction per cycle when ready is combinational and stall=0.
- Stall: ifid_* are bit-identical for every stalled cycle. At most one instruction is captured during a stall. The buffered instruction appears on IF/ID one cycle after stall falls.
- Redirect at edge N: ifid_valid=0 in cycle N+1. The first fetch from redirect_pc is issued in N+1, or after the DISCARD completion edge.
- Redirect and stall in the same cycle: redirect wins and the bubble is inserted regardless of stall.
- halted rises the cycle after the HLT enters IF/ID. It falls the cycle after a redirect.

## Test plan
- Reset, combinational memory holding ADD at 0x0000/0x0002/0x0004 -> ifid_pc_inc sequence 0x0002, 0x0004, 0x0006 on consecutive cycles; ifid_valid=1 from cycle 1.
- Memory with 2-cycle ready latency -> one bubble (ifid_valid=0) between instructions; imem_addr stable 0x0010 during the wait.
- Stall held 3 cycles while ready=1 at pc=0x0020 -> IF/ID frozen; buffer captures instr@0x0020; pc=0x0022; no req during BUFFERED; instr@0x0020 reaches IF/ID one cycle after stall drops.
- Redirect to 0x0101 during an outstanding 3-cycle request at 0x0040 -> pc=0x0100; req stays at 0x0040 until ready; that data is dropped; next fetch is at 0x0100.
- HLT (0xF000) at 0x0008 -> ifid_instr=0xF000; halted=1; imem_req=0; pc stays 0x0008. A later redirect to 0x0030 clears halted and fetches at 0x0030.
- pc=0xFFFE with stall+redirect in the same cycle -> redirect wins. Separately, an accept at 0xFFFE gives ifid_pc_inc=0x0000 and pc=0x0000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a variable-latency req/ready
// handshake, loads IF/ID, absorbs decode stalls in a one-entry skid buffer, follows redirects, stops on HLT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic        ifid_valid,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_inc,
  output logic [15:0] pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    BUFFERED = 2'd1,
    DISCARD  = 2'd2,
    HALT     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] disc_addr_q, disc_addr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [15:0] ifid_instr_q, ifid_instr_d;
  logic [15:0] ifid_pc_inc_q, ifid_pc_inc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [15:0] buf_instr_q, buf_instr_d;
  logic [15:0] buf_pc_inc_q, buf_pc_inc_d;
  logic        buf_hlt_q, buf_hlt_d;
  logic [15:0] pc_inc_s;
  logic        rdata_hlt_s;

  assign pc_inc_s    = pc_q + 16'd2;
  assign rdata_hlt_s = (imem_rdata[15:12] == HLT_OPCODE);

  // Next-state logic; a redirect overrides stall and any accept in every state.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    disc_addr_d   = disc_addr_q;
    ifid_valid_d  = ifid_valid_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_inc_d = ifid_pc_inc_q;
    buf_valid_d   = buf_valid_q;
    buf_instr_d   = buf_instr_q;
    buf_pc_inc_d  = buf_pc_inc_q;
    buf_hlt_d     = buf_hlt_q;
    if (redirect_en) begin
      pc_d         = {redirect_pc[15:1], 1'b0};
      ifid_valid_d = 1'b0;
      buf_valid_d  = 1'b0;
      case (state_q)
        FETCH: begin
          if (!imem_ready) begin
            state_d     = DISCARD;
            disc_addr_d = pc_q;
          end else begin
            state_d = FETCH;
          end
        end
        DISCARD: state_d = imem_ready ? FETCH : DISCARD;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ready) begin
            if (!stall) begin
              ifid_valid_d  = 1'b1;
              ifid_instr_d  = imem_rdata;
              ifid_pc_inc_d = pc_inc_s;
              state_d       = rdata_hlt_s ? HALT : FETCH;
            end else begin
              buf_valid_d  = 1'b1;
              buf_instr_d  = imem_rdata;
              buf_pc_inc_d = pc_inc_s;
              buf_hlt_d    = rdata_hlt_s;
              state_d      = BUFFERED;
            end
            // A HLT leaves the PC pointing at itself.
            if (!rdata_hlt_s) begin
              pc_d = pc_inc_s;
            end else begin
              pc_d = pc_q;
            end
          end else if (!stall) begin
            ifid_valid_d = 1'b0;
          end else begin
            ifid_valid_d = ifid_valid_q;
          end
        end
        BUFFERED: begin
          if (!stall) begin
            ifid_valid_d  = 1'b1;
            ifid_instr_d  = buf_instr_q;
            ifid_pc_inc_d = buf_pc_inc_q;
            buf_valid_d   = 1'b0;
            state_d       = buf_hlt_q ? HALT : FETCH;
          end else begin
            state_d = BUFFERED;
          end
        end
        DISCARD: begin
          if (imem_ready) begin
            state_d = FETCH;
          end else begin
            state_d = DISCARD;
          end
        end
        HALT: begin
          if (!stall) begin
            ifid_valid_d = 1'b0;
          end else begin
            ifid_valid_d = ifid_valid_q;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      disc_addr_q   <= 16'h0000;
      ifid_valid_q  <= 1'b0;
      ifid_instr_q  <= 16'h0000;
      ifid_pc_inc_q <= 16'h0000;
      buf_valid_q   <= 1'b0;
      buf_instr_q   <= 16'h0000;
      buf_pc_inc_q  <= 16'h0000;
      buf_hlt_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      disc_addr_q   <= disc_addr_d;
      ifid_valid_q  <= ifid_valid_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_inc_q <= ifid_pc_inc_d;
      buf_valid_q   <= buf_valid_d;
      buf_instr_q   <= buf_instr_d;
      buf_pc_inc_q  <= buf_pc_inc_d;
      buf_hlt_q     <= buf_hlt_d;
    end
  end

  assign imem_req    = (state_q == FETCH) || (state_q == DISCARD);
  assign imem_addr   = (state_q == DISCARD) ? disc_addr_q : pc_q;
  assign pc          = pc_q;
  assign halted      = (state_q == HALT);
  assign ifid_valid  = ifid_valid_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc_inc = ifid_pc_inc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: random stall/redirect/ready traffic against a
// transaction-level model of the fetch stream (PC, skid queue, halt and discard flags).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_inc;
  logic [15:0] pc;
  logic        halted;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(16'h0000), .HLT_OPCODE(4'hF)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .ifid_valid(ifid_valid),
    .ifid_instr(ifid_instr), .ifid_pc_inc(ifid_pc_inc), .pc(pc), .halted(halted)
  );

  // Program image: a HLT every 32 instructions, no other word carries the HLT opcode.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    if (a[5:1] == 5'h1F) return {4'hF, a[11:0]};
    w = a * 16'h9E37 + 16'h0155;
    if (w[15:12] == 4'hF) w[15] = 1'b0;
    return w;
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_inc;
    logic        hlt;
  } skid_t;

  logic [15:0] m_pc, m_disc_addr, m_ifi, m_ifp;
  logic        m_ifv, m_halt, m_discard;
  skid_t       m_skid[$];

  task automatic model_reset();
    m_pc = 16'h0000; m_disc_addr = 16'h0000; m_ifi = 16'h0000; m_ifp = 16'h0000;
    m_ifv = 1'b0; m_halt = 1'b0; m_discard = 1'b0;
    m_skid.delete();
  endtask

  function automatic logic exp_req();
    return !m_halt && (m_skid.size() == 0);
  endfunction

  task automatic check_outputs();
    check("imem_req",    {15'd0, imem_req},   {15'd0, exp_req()});
    check("imem_addr",   imem_addr,           m_discard ? m_disc_addr : m_pc);
    check("pc",          pc,                  m_pc);
    check("ifid_valid",  {15'd0, ifid_valid}, {15'd0, m_ifv});
    check("ifid_instr",  ifid_instr,          m_ifi);
    check("ifid_pc_inc", ifid_pc_inc,         m_ifp);
    check("halted",      {15'd0, halted},     {15'd0, m_halt});
  endtask

  task automatic model_step(input logic st, input logic rd, input logic [15:0] rpc,
                            input logic rdy, input logic [15:0] data);
    logic        hlt;
    logic [15:0] inc;
    skid_t       s;
    if (rd) begin
      if (m_discard) begin
        m_discard = !rdy;
      end else if (exp_req() && !rdy) begin
        m_discard   = 1'b1;
        m_disc_addr = m_pc;
      end
      m_pc   = rpc & 16'hFFFE;
      m_ifv  = 1'b0;
      m_halt = 1'b0;
      m_skid.delete();
    end else if (m_discard) begin
      if (rdy) m_discard = 1'b0;
    end else if (m_halt) begin
      if (!st) m_ifv = 1'b0;
    end else if (m_skid.size() != 0) begin
      if (!st) begin
        s = m_skid.pop_front();
        m_ifv = 1'b1; m_ifi = s.instr; m_ifp = s.pc_inc; m_halt = s.hlt;
      end
    end else if (rdy) begin
      hlt = (data[15:12] == 4'hF);
      inc = m_pc + 16'd2;
      if (!st) begin
        m_ifv = 1'b1; m_ifi = data; m_ifp = inc; m_halt = hlt;
      end else begin
        m_skid.push_back('{instr: data, pc_inc: inc, hlt: hlt});
      end
      if (!hlt) m_pc = inc;
    end else if (!st) begin
      m_ifv = 1'b0;
    end
  endtask

  int rdy_pct;

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 16'h0000; imem_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    rdy_pct = 100;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 2000) begin
        // Abandon whatever is in flight with a mid-run reset.
        rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; imem_ready = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
      end else begin
        if (cyc % 250 == 0) begin
          case ($urandom_range(2))
            0:       rdy_pct = 100;
            1:       rdy_pct = 60;
            default: rdy_pct = 30;
          endcase
        end
        stall       = ($urandom_range(99) < 20);
        redirect_en = ($urandom_range(99) < 7);
        case ($urandom_range(3))
          0:       redirect_pc = 16'hFFFE;
          1:       redirect_pc = 16'hFFFD;
          default: redirect_pc = 16'($urandom);
        endcase
        imem_ready = imem_req && ($urandom_range(99) < rdy_pct);
        @(negedge clk);
        check_outputs();
        model_step(stall, redirect_en, redirect_pc, imem_ready, imem_rdata);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
